ext_bus_arbiter: RTL and testbench

Shares the single external memory bus between two requesters:
- the CPU-side strobes that the memory control block drives outward for accesses it cannot serve internally;
- a DMA-style port, used by the program-RAM loader and peripherals.

The block arbitrates between them, stretches every external access to a fixed number of wait states, latches read data, and stalls the CPU through an active-low wait line until its access completes.

---
 rtl/ext_bus_arbiter_pkg.sv | 20 ++
 rtl/ext_bus_arbiter_if.sv | 48 ++++
 rtl/ext_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_ext_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// State encodings, default timing parameters and the wait-counter sizing rule.
package ext_bus_arbiter_pkg;

  localparam int DEFAULT_WAIT_STATES = 2;
  localparam int DEFAULT_ADDR_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_ACC  = 2'd1,
    ST_DMA_ACC  = 2'd2,
    ST_CPU_HOLD = 2'd3
  } state_t;

  // The counter only ever holds 0..WAIT_STATES, loaded at grant.
  function automatic int cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/ext_bus_arbiter_if.sv
// CPU strobes, DMA port and external memory bus as one bundle.
// master = requesters plus memory side, slave = the arbiter.
interface ext_bus_arbiter_if #(
  parameter int ADDR_W = ext_bus_arbiter_pkg::DEFAULT_ADDR_W
);

  logic              cpu_n_mreq;
  logic              cpu_n_rd;
  logic              cpu_n_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_n_wait;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic [7:0]        dma_rdata;
  logic              dma_ack;

  logic [ADDR_W-1:0] ext_addr;
  logic [7:0]        ext_dout;
  logic              ext_dout_en;
  logic [7:0]        ext_din;
  logic              ext_n_mreq;
  logic              ext_n_rd;
  logic              ext_n_wr;

  modport master (
    output cpu_n_mreq, cpu_n_rd, cpu_n_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_n_wait,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ext_addr, ext_dout, ext_dout_en, ext_n_mreq, ext_n_rd, ext_n_wr,
    output ext_din
  );

  modport slave (
    input  cpu_n_mreq, cpu_n_rd, cpu_n_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_n_wait,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ext_addr, ext_dout, ext_dout_en, ext_n_mreq, ext_n_rd, ext_n_wr,
    input  ext_din
  );

endinterface

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter of CPU and DMA onto one external bus; strobes last WAIT_STATES+1 cycles,
// read data / dma_ack appear WAIT_STATES+2 cycles after the request; the CPU is stalled via cpu_n_wait.
module ext_bus_arbiter
  import ext_bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int ADDR_W      = DEFAULT_ADDR_W
) (
  input logic              clk,
  input logic              n_reset,
  ext_bus_arbiter_if.slave bus
);

  localparam int               CNT_W    = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_dma_q, last_dma_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [7:0]        ext_dout_q, ext_dout_d;
  logic              ext_dout_en_q, ext_dout_en_d;
  logic              ext_n_mreq_q, ext_n_mreq_d;
  logic              ext_n_rd_q, ext_n_rd_d;
  logic              ext_n_wr_q, ext_n_wr_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        dma_rdata_q, dma_rdata_d;
  logic              dma_ack_q, dma_ack_d;

  logic cpu_req;
  logic grant_cpu;
  logic grant_dma;
  logic sel_wr;
  logic cnt_zero;

  // Both strobes low or both high is a malformed cycle, not a request.
  assign cpu_req   = !bus.cpu_n_mreq && (bus.cpu_n_rd != bus.cpu_n_wr);
  assign grant_cpu = cpu_req && (!bus.dma_req || last_dma_q);
  assign grant_dma = bus.dma_req && (!cpu_req || !last_dma_q);
  assign sel_wr    = grant_cpu ? !bus.cpu_n_wr : bus.dma_we;
  assign cnt_zero  = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_dma_q    <= 1'b1;
      ext_addr_q    <= '0;
      ext_dout_q    <= '0;
      ext_dout_en_q <= 1'b0;
      ext_n_mreq_q  <= 1'b1;
      ext_n_rd_q    <= 1'b1;
      ext_n_wr_q    <= 1'b1;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      dma_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_dma_q    <= last_dma_d;
      ext_addr_q    <= ext_addr_d;
      ext_dout_q    <= ext_dout_d;
      ext_dout_en_q <= ext_dout_en_d;
      ext_n_mreq_q  <= ext_n_mreq_d;
      ext_n_rd_q    <= ext_n_rd_d;
      ext_n_wr_q    <= ext_n_wr_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      dma_ack_q     <= dma_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_d = ST_CPU_ACC;
        end else if (grant_dma) begin
          state_d = ST_DMA_ACC;
        end
      end
      ST_CPU_ACC:  if (cnt_zero) state_d = ST_CPU_HOLD;
      ST_DMA_ACC:  if (cnt_zero) state_d = ST_IDLE;
      ST_CPU_HOLD: if (bus.cpu_n_mreq) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    last_dma_d    = last_dma_q;
    ext_addr_d    = ext_addr_q;
    ext_dout_d    = ext_dout_q;
    ext_dout_en_d = ext_dout_en_q;
    ext_n_mreq_d  = ext_n_mreq_q;
    ext_n_rd_d    = ext_n_rd_q;
    ext_n_wr_d    = ext_n_wr_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    dma_ack_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_cpu || grant_dma) begin
          ext_addr_d    = grant_cpu ? bus.cpu_addr : bus.dma_addr;
          ext_n_mreq_d  = 1'b0;
          ext_n_rd_d    = sel_wr;
          ext_n_wr_d    = !sel_wr;
          ext_dout_en_d = sel_wr;
          if (sel_wr) begin
            ext_dout_d = grant_cpu ? bus.cpu_wdata : bus.dma_wdata;
          end
          cnt_d      = CNT_LOAD;
          last_dma_d = grant_dma;
        end
      end
      ST_CPU_ACC, ST_DMA_ACC: begin
        // Last strobe cycle: the memory is still driving ext_din at this edge.
        if (cnt_zero) begin
          ext_n_mreq_d  = 1'b1;
          ext_n_rd_d    = 1'b1;
          ext_n_wr_d    = 1'b1;
          ext_dout_en_d = 1'b0;
          if (!ext_n_rd_q) begin
            if (state_q == ST_CPU_ACC) begin
              cpu_rdata_d = bus.ext_din;
            end else begin
              dma_rdata_d = bus.ext_din;
            end
          end
          if (state_q == ST_DMA_ACC) begin
            dma_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.cpu_n_wait  = !n_reset ? 1'b1 : !(cpu_req && (state_q != ST_CPU_HOLD));
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.dma_rdata   = dma_rdata_q;
  assign bus.dma_ack     = dma_ack_q;
  assign bus.ext_addr    = ext_addr_q;
  assign bus.ext_dout    = ext_dout_q;
  assign bus.ext_dout_en = ext_dout_en_q;
  assign bus.ext_n_mreq  = ext_n_mreq_q;
  assign bus.ext_n_rd    = ext_n_rd_q;
  assign bus.ext_n_wr    = ext_n_wr_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench: dut_a runs with two wait states, dut_b with none (back-to-back DMA).
module tb_ext_bus_arbiter;

  logic clk;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;

  ext_bus_arbiter_if #(.ADDR_W(16)) bus_a ();
  ext_bus_arbiter_if #(.ADDR_W(16)) bus_b ();

  ext_bus_arbiter #(.WAIT_STATES(2), .ADDR_W(16)) dut_a (.clk(clk), .n_reset(n_reset), .bus(bus_a));
  ext_bus_arbiter #(.WAIT_STATES(0), .ADDR_W(16)) dut_b (.clk(clk), .n_reset(n_reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_rd = 1'b1; bus_a.cpu_n_wr = 1'b1;
    bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_a.dma_req = 1'b0; bus_a.dma_we = 1'b0; bus_a.dma_addr = '0; bus_a.dma_wdata = '0;
    bus_a.ext_din = '0;
    bus_b.cpu_n_mreq = 1'b1; bus_b.cpu_n_rd = 1'b1; bus_b.cpu_n_wr = 1'b1;
    bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    bus_b.dma_req = 1'b0; bus_b.dma_we = 1'b0; bus_b.dma_addr = '0; bus_b.dma_wdata = '0;
    bus_b.ext_din = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_reset = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    n_reset = 1'b0;
    bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0;
    tick(); tick();
    total++; if (bus_a.ext_n_mreq !== 1'b1) begin bad++; $display("FAIL reset_n_mreq got=%b exp=1", bus_a.ext_n_mreq); end
    total++; if ({bus_a.ext_n_rd, bus_a.ext_n_wr} !== 2'b11) begin bad++; $display("FAIL reset_rd_wr got=%b exp=11", {bus_a.ext_n_rd, bus_a.ext_n_wr}); end
    total++; if (bus_a.ext_dout_en !== 1'b0) begin bad++; $display("FAIL reset_dout_en got=%b exp=0", bus_a.ext_dout_en); end
    total++; if (bus_a.ext_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", bus_a.ext_addr); end
    total++; if (bus_a.ext_dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus_a.ext_dout); end
    total++; if ({bus_a.cpu_rdata, bus_a.dma_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", {bus_a.cpu_rdata, bus_a.dma_rdata}); end
    total++; if (bus_a.dma_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus_a.dma_ack); end
    total++; if (bus_a.cpu_n_wait !== 1'b1) begin bad++; $display("FAIL reset_n_wait got=%b exp=1", bus_a.cpu_n_wait); end
    total++; if (bus_b.ext_n_mreq !== 1'b1) begin bad++; $display("FAIL reset_b_n_mreq got=%b exp=1", bus_b.ext_n_mreq); end
    idle_inputs();
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    int  rd_low = 0, wait_low = 0, rd_first = -1;
    bit  hold_ok = 1'b1;
    bus_a.ext_din = 8'h5A; bus_a.cpu_addr = 16'h2000;
    bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (!bus_a.ext_n_rd) begin rd_low++; if (rd_first < 0) rd_first = c; end
      if (!bus_a.cpu_n_wait) wait_low++;
      if (c == 1) begin
        total++; if (bus_a.ext_addr !== 16'h2000) begin bad++; $display("FAIL cpu_rd_addr got=%h exp=2000", bus_a.ext_addr); end
      end
      if (c == 4) begin
        total++; if (bus_a.cpu_rdata !== 8'h5A) begin bad++; $display("FAIL cpu_rd_data got=%h exp=5a", bus_a.cpu_rdata); end
      end
      if (c >= 4 && bus_a.ext_n_mreq !== 1'b1) hold_ok = 1'b0;
      tick();
    end
    total++; if (rd_low != 3) begin bad++; $display("FAIL cpu_rd_len got=%0d exp=3", rd_low); end
    total++; if (rd_first != 1) begin bad++; $display("FAIL cpu_rd_start got=%0d exp=1", rd_first); end
    total++; if (wait_low != 4) begin bad++; $display("FAIL cpu_rd_wait got=%0d exp=4", wait_low); end
    total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL cpu_rd_hold got=%b exp=1", hold_ok); end
    bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_rd = 1'b1;
    tick(); tick();
  endtask

  task automatic test_dma_write();
    int wr_low = 0, wr_first = -1, ack_cnt = 0, ack_c = -1;
    bit win_ok = 1'b1;
    bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b1; bus_a.dma_addr = 16'h1234; bus_a.dma_wdata = 8'hC3;
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        bus_a.dma_req = 1'b0; bus_a.dma_we = 1'b0; bus_a.dma_addr = 16'hFFFF; bus_a.dma_wdata = 8'h00;
        #1;
      end
      if (!bus_a.ext_n_wr) begin
        wr_low++;
        if (wr_first < 0) wr_first = c;
        if (bus_a.ext_dout !== 8'hC3 || bus_a.ext_dout_en !== 1'b1 || bus_a.ext_addr !== 16'h1234 ||
            bus_a.ext_n_rd !== 1'b1 || bus_a.ext_n_mreq !== 1'b0) win_ok = 1'b0;
      end
      if (bus_a.dma_ack) begin ack_cnt++; ack_c = c; end
      if (c == 4) begin
        total++; if (bus_a.ext_dout_en !== 1'b0) begin bad++; $display("FAIL dma_wr_dout_off got=%b exp=0", bus_a.ext_dout_en); end
      end
      tick();
    end
    total++; if (wr_low != 3) begin bad++; $display("FAIL dma_wr_len got=%0d exp=3", wr_low); end
    total++; if (wr_first != 1) begin bad++; $display("FAIL dma_wr_start got=%0d exp=1", wr_first); end
    total++; if (win_ok !== 1'b1) begin bad++; $display("FAIL dma_wr_window got=%b exp=1", win_ok); end
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL dma_wr_ack_cnt got=%0d exp=1", ack_cnt); end
    total++; if (ack_c != 4) begin bad++; $display("FAIL dma_wr_ack_cycle got=%0d exp=4", ack_c); end
  endtask

  task automatic test_tie();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin
        bus_a.cpu_addr = 16'h0100; bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0;
        bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dma_addr = 16'h0200; bus_a.ext_din = 8'h11;
      end
      if (c == 4) begin bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_rd = 1'b1; bus_a.ext_din = 8'h22; end
      if (c == 5) begin bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0; end
      if (c == 6) bus_a.dma_req = 1'b0;
      if (c == 9) bus_a.ext_din = 8'h33;
      #1;
      if (c == 1) begin
        total++; if (bus_a.ext_addr !== 16'h0100) begin bad++; $display("FAIL tie1_cpu_addr got=%h exp=0100", bus_a.ext_addr); end
      end
      if (c == 4) begin
        total++; if (bus_a.cpu_rdata !== 8'h11) begin bad++; $display("FAIL tie1_cpu_data got=%h exp=11", bus_a.cpu_rdata); end
      end
      if (c == 5) begin
        total++; if (bus_a.cpu_n_wait !== 1'b0) begin bad++; $display("FAIL tie2_wait got=%b exp=0", bus_a.cpu_n_wait); end
      end
      if (c == 6) begin
        total++; if (bus_a.ext_addr !== 16'h0200 || bus_a.ext_n_rd !== 1'b0) begin bad++; $display("FAIL tie2_dma_wins got=%h/%b exp=0200/0", bus_a.ext_addr, bus_a.ext_n_rd); end
      end
      if (c == 9) begin
        total++; if (bus_a.dma_ack !== 1'b1 || bus_a.dma_rdata !== 8'h22) begin bad++; $display("FAIL tie2_dma_done got=%b/%h exp=1/22", bus_a.dma_ack, bus_a.dma_rdata); end
      end
      if (c == 10) begin
        total++; if (bus_a.ext_addr !== 16'h0100 || bus_a.ext_n_rd !== 1'b0) begin bad++; $display("FAIL tie2_cpu_next got=%h/%b exp=0100/0", bus_a.ext_addr, bus_a.ext_n_rd); end
      end
      if (c == 13) begin
        total++; if (bus_a.cpu_rdata !== 8'h33 || bus_a.cpu_n_wait !== 1'b1) begin bad++; $display("FAIL tie2_cpu_done got=%h/%b exp=33/1", bus_a.cpu_rdata, bus_a.cpu_n_wait); end
      end
      tick();
    end
    bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_rd = 1'b1;
    tick(); tick();
  endtask

  task automatic test_both_strobes();
    bit quiet = 1'b1, no_wait = 1'b1;
    bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0; bus_a.cpu_n_wr = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (bus_a.ext_n_mreq !== 1'b1 || bus_a.ext_n_rd !== 1'b1 || bus_a.ext_n_wr !== 1'b1) quiet = 1'b0;
      if (bus_a.cpu_n_wait !== 1'b1) no_wait = 1'b0;
      tick();
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL both_low_strobes got=%b exp=1", quiet); end
    total++; if (no_wait !== 1'b1) begin bad++; $display("FAIL both_low_wait got=%b exp=1", no_wait); end
    bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_rd = 1'b1; bus_a.cpu_n_wr = 1'b1;
    tick();
  endtask

  task automatic test_cpu_abort();
    int rd_low = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin bus_a.cpu_addr = 16'h0555; bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0; end
      if (c == 2 || c == 7) begin bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_rd = 1'b1; end
      if (c == 5) begin bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_rd = 1'b0; end
      #1;
      if (c <= 4 && !bus_a.ext_n_rd) rd_low++;
      if (c == 5) begin
        total++; if (bus_a.ext_n_mreq !== 1'b1 || bus_a.cpu_n_wait !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b/%b exp=1/0", bus_a.ext_n_mreq, bus_a.cpu_n_wait); end
      end
      if (c == 6) begin
        total++; if (bus_a.ext_n_mreq !== 1'b0) begin bad++; $display("FAIL abort_regrant got=%b exp=0", bus_a.ext_n_mreq); end
      end
      tick();
    end
    total++; if (rd_low != 3) begin bad++; $display("FAIL abort_len got=%0d exp=3", rd_low); end
  endtask

  task automatic test_reset_mid();
    int early_ack = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        bus_a.cpu_addr = 16'h3000; bus_a.cpu_wdata = 8'h77; bus_a.cpu_n_mreq = 1'b0; bus_a.cpu_n_wr = 1'b0;
      end
      if (c == 2) n_reset = 1'b0;
      if (c == 4) begin n_reset = 1'b1; bus_a.cpu_n_mreq = 1'b1; bus_a.cpu_n_wr = 1'b1; end
      if (c == 5) begin bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dma_addr = 16'h4444; bus_a.ext_din = 8'h9C; end
      if (c == 6) bus_a.dma_req = 1'b0;
      #1;
      if (c >= 3 && c <= 8 && bus_a.dma_ack) early_ack++;
      if (c == 2) begin
        total++; if (bus_a.ext_n_wr !== 1'b0) begin bad++; $display("FAIL rmid_active got=%b exp=0", bus_a.ext_n_wr); end
      end
      if (c == 3) begin
        total++; if ({bus_a.ext_n_mreq, bus_a.ext_n_rd, bus_a.ext_n_wr, bus_a.ext_dout_en} !== 4'b1110) begin bad++; $display("FAIL rmid_strobes got=%b exp=1110", {bus_a.ext_n_mreq, bus_a.ext_n_rd, bus_a.ext_n_wr, bus_a.ext_dout_en}); end
        total++; if (bus_a.cpu_n_wait !== 1'b1 || bus_a.ext_addr !== 16'h0000) begin bad++; $display("FAIL rmid_wait_addr got=%b/%h exp=1/0000", bus_a.cpu_n_wait, bus_a.ext_addr); end
      end
      if (c == 6) begin
        total++; if (bus_a.ext_addr !== 16'h4444 || bus_a.ext_n_rd !== 1'b0) begin bad++; $display("FAIL rmid_fresh got=%h/%b exp=4444/0", bus_a.ext_addr, bus_a.ext_n_rd); end
      end
      if (c == 9) begin
        total++; if (bus_a.dma_ack !== 1'b1 || bus_a.dma_rdata !== 8'h9C) begin bad++; $display("FAIL rmid_fresh_done got=%b/%h exp=1/9c", bus_a.dma_ack, bus_a.dma_rdata); end
      end
      tick();
    end
    total++; if (early_ack != 0) begin bad++; $display("FAIL rmid_no_ack got=%0d exp=0", early_ack); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ack_mask = '0;
    logic [9:0] rd_mask  = '0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin bus_b.dma_req = 1'b1; bus_b.dma_we = 1'b0; bus_b.dma_addr = 16'h0040; bus_b.ext_din = 8'hA5; end
      if (c == 6) bus_b.dma_req = 1'b0;
      #1;
      ack_mask[c] = bus_b.dma_ack;
      rd_mask[c]  = !bus_b.ext_n_rd;
      if (c == 2) begin
        total++; if (bus_b.dma_rdata !== 8'hA5) begin bad++; $display("FAIL b2b_data got=%h exp=a5", bus_b.dma_rdata); end
      end
      tick();
    end
    total++; if (ack_mask !== 10'b0001010100) begin bad++; $display("FAIL b2b_acks got=%b exp=0001010100", ack_mask); end
    total++; if (rd_mask !== 10'b0000101010) begin bad++; $display("FAIL b2b_strobes got=%b exp=0000101010", rd_mask); end
  endtask

  initial begin
    n_reset = 1'b0;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_tie();
    test_both_strobes();
    test_cpu_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
